// File: rtl/axis_bram_pkg.sv
// Shared definitions for the AXI-Stream <-> BRAM line adapter: FSM encoding
// and the compile-time width helpers.
package axis_bram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_FILL,
    ST_WR_COMMIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_LOAD,
    ST_RD_SEND,
    ST_DONE
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // A one-word line still needs a 1-bit pointer.
  function automatic int ptr_width(input int words);
    return (clog2(words) < 1) ? 1 : clog2(words);
  endfunction

endpackage

// File: rtl/axis_bram_adapter_v2_0_line_buf.sv
// One BRAM line held as individually writable words, with a parallel load
// from BRAM, a word-select read port and the full line for BRAM write data.
module axis_bram_line_buf #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 36,
  parameter int PTR_W  = 6
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [PTR_W-1:0]        wr_idx,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    load_en,
  input  logic [DATA_W*WORDS-1:0] load_data,
  input  logic [PTR_W-1:0]        rd_idx,
  output logic [DATA_W-1:0]       rd_data,
  output logic [DATA_W*WORDS-1:0] line
);

  logic [WORDS-1:0][DATA_W-1:0] word_arr;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [DATA_W-1:0] word_reg;

      // Clear wins so a discarded or committed line never leaks into the next.
      always_ff @(posedge clk) begin
        if (!rstn || clr)
          word_reg <= '0;
        else if (load_en)
          word_reg <= load_data[gi*DATA_W +: DATA_W];
        else if (wr_en && (wr_idx == PTR_W'(gi)))
          word_reg <= wr_data;
      end

      assign word_arr[gi] = word_reg;
    end
  endgenerate

  assign line    = word_arr;
  assign rd_data = (int'(rd_idx) < WORDS) ? word_arr[rd_idx] : '0;

endmodule

// File: rtl/axis_bram_adapter_v2_0.sv
// Moves whole BRAM lines between an AXI-Stream port and a BRAM port:
// stream-to-BRAM packs words into a line, BRAM-to-stream unpacks them.
module axis_bram_adapter_v2_0
  import axis_bram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 36,
  parameter int ADDR_W         = 12,
  localparam int LINE_W        = DATA_W * WORDS_PER_LINE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] line_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] lines_done,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [LINE_W-1:0] bram_din,
  input  logic [LINE_W-1:0] bram_dout
);

  localparam int                PTR_W    = ptr_width(WORDS_PER_LINE);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(WORDS_PER_LINE - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_reg, state_next;
  logic              mode_reg, mode_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] lines_reg, lines_next;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;
  logic              last_reg, last_next;
  logic              busy_reg, done_reg, s_tready_reg, m_tvalid_reg, m_tlast_reg;
  logic              bram_en_reg, bram_we_reg;
  logic              buf_clr, buf_wr, buf_load;
  state_t            cont_state;

  // After a line, the next one repeats the direction latched at start.
  assign cont_state = mode_reg ? ST_RD_REQ : ST_WR_FILL;

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    lines_next = lines_reg;
    ptr_next   = ptr_reg;
    last_next  = last_reg;
    buf_clr    = 1'b0;
    buf_wr     = 1'b0;
    buf_load   = 1'b0;
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
      ptr_next   = '0;
      last_next  = 1'b0;
      buf_clr    = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            mode_next  = mode;
            addr_next  = base_addr;
            cnt_next   = line_count;
            lines_next = '0;
            ptr_next   = '0;
            last_next  = 1'b0;
            buf_clr    = 1'b1;
            if (line_count == '0) state_next = ST_DONE;
            else                  state_next = mode ? ST_RD_REQ : ST_WR_FILL;
          end
        end
        ST_WR_FILL: begin
          if (s_tvalid) begin
            buf_wr   = 1'b1;
            ptr_next = ptr_reg + PTR_ONE;
            if (s_tlast) last_next = 1'b1;
            if ((ptr_reg == LAST_PTR) || s_tlast) state_next = ST_WR_COMMIT;
          end
        end
        ST_WR_COMMIT: begin
          lines_next = lines_reg + ADDR_ONE;
          addr_next  = addr_reg + ADDR_ONE;
          ptr_next   = '0;
          last_next  = 1'b0;
          buf_clr    = 1'b1;
          state_next = (last_reg || (lines_next == cnt_reg)) ? ST_DONE : cont_state;
        end
        ST_RD_REQ:  state_next = ST_RD_WAIT;
        ST_RD_WAIT: state_next = ST_RD_LOAD;
        ST_RD_LOAD: begin
          buf_load   = 1'b1;
          ptr_next   = '0;
          state_next = ST_RD_SEND;
        end
        ST_RD_SEND: begin
          if (m_tvalid_reg && m_tready) begin
            ptr_next = ptr_reg + PTR_ONE;
            if (ptr_reg == LAST_PTR) begin
              lines_next = lines_reg + ADDR_ONE;
              addr_next  = addr_reg + ADDR_ONE;
              state_next = (lines_next == cnt_reg) ? ST_DONE : cont_state;
            end
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_reg.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= 1'b0;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      lines_reg    <= '0;
      ptr_reg      <= '0;
      last_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      s_tready_reg <= 1'b0;
      m_tvalid_reg <= 1'b0;
      m_tlast_reg  <= 1'b0;
      bram_en_reg  <= 1'b0;
      bram_we_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      lines_reg    <= lines_next;
      ptr_reg      <= ptr_next;
      last_reg     <= last_next;
      busy_reg     <= (state_next != ST_IDLE);
      done_reg     <= (state_next == ST_DONE);
      s_tready_reg <= (state_next == ST_WR_FILL);
      m_tvalid_reg <= (state_next == ST_RD_SEND);
      m_tlast_reg  <= (state_next == ST_RD_SEND) && (ptr_next == LAST_PTR) &&
                      (lines_next == (cnt_next - ADDR_ONE));
      bram_en_reg  <= (state_next == ST_WR_COMMIT) || (state_next == ST_RD_REQ);
      bram_we_reg  <= (state_next == ST_WR_COMMIT);
    end
  end

  axis_bram_line_buf #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS_PER_LINE),
    .PTR_W  (PTR_W)
  ) u_line_buf (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (buf_clr),
    .wr_en     (buf_wr),
    .wr_idx    (ptr_reg),
    .wr_data   (s_tdata),
    .load_en   (buf_load),
    .load_data (bram_dout),
    .rd_idx    (ptr_reg),
    .rd_data   (m_tdata),
    .line      (bram_din)
  );

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign lines_done = lines_reg;
  assign s_tready   = s_tready_reg;
  assign m_tvalid   = m_tvalid_reg;
  assign m_tlast    = m_tlast_reg;
  assign bram_en    = bram_en_reg;
  assign bram_we    = bram_we_reg;
  assign bram_addr  = addr_reg;

endmodule

// File: tb/tb_axis_bram_adapter_v2_0.sv
// Directed bench for axis_bram_adapter_v2_0 with 4-word lines and a
// behavioural one-cycle-latency BRAM.
module tb_axis_bram_adapter_v2_0;

  localparam int DW = 32;
  localparam int WPL = 4;
  localparam int AW = 12;
  localparam int LW = DW * WPL;

  logic          clk = 1'b0;
  logic          rstn, start, abort, mode;
  logic [AW-1:0] base_addr, line_count;
  logic          busy, done;
  logic [AW-1:0] lines_done;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [LW-1:0] bram_din, bram_dout;

  int total = 0;
  int bad = 0;

  logic [LW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_addr_q[$];
  logic [LW-1:0] wr_data_q[$];
  logic [AW-1:0] rd_addr_q[$];
  logic [DW-1:0] beat_q[$];
  logic          beat_last_q[$];
  int            done_cnt = 0;
  int            en_cnt = 0;

  always #5 clk = ~clk;

  axis_bram_adapter_v2_0 #(.DATA_W(DW), .WORDS_PER_LINE(WPL), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .mode(mode),
    .base_addr(base_addr), .line_count(line_count), .busy(busy), .done(done),
    .lines_done(lines_done), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  // BRAM model plus transaction monitor
  always @(posedge clk) begin
    if (bram_en) begin
      en_cnt++;
      if (bram_we) begin
        mem[bram_addr] <= bram_din;
        wr_addr_q.push_back(bram_addr);
        wr_data_q.push_back(bram_din);
      end else begin
        bram_dout <= mem[bram_addr];
        rd_addr_q.push_back(bram_addr);
      end
    end
    if (done) done_cnt++;
    if (m_tvalid && m_tready) begin
      beat_q.push_back(m_tdata);
      beat_last_q.push_back(m_tlast);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    beat_q.delete();
    beat_last_q.delete();
  endtask

  task automatic do_start(input logic m, input logic [AW-1:0] b, input logic [AW-1:0] c);
    mode = m; base_addr = b; line_count = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int n;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
    n = 0;
    while (!s_tready && n < 20) begin
      tick();
      n++;
    end
    check("s_tready_wait", (n < 20), 1'b1);
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check(tag, done, 1'b1);
  endtask

  initial begin
    int cyc;
    int n;
    logic stall_prev;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic [DW-1:0] exp_beats [8];

    rstn = 1'b0; start = 0; abort = 0; mode = 0; base_addr = '0; line_count = '0;
    s_tdata = '0; s_tvalid = 0; s_tlast = 0; m_tready = 0; bram_dout = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_lines", lines_done, '0);
    check("rst_sready", s_tready, 1'b0);
    check("rst_mvalid", m_tvalid, 1'b0);
    check("rst_bram_en", bram_en, 1'b0);
    check("rst_addr", bram_addr, '0);
    check("rst_din", bram_din, '0);
    rstn = 1'b1;
    tick();

    // Two full write lines, tlast on the final beat
    clear_logs();
    n = done_cnt;
    do_start(1'b0, 12'h010, 12'd2);
    check("wr1_busy", busy, 1'b1);
    check("wr1_sready", s_tready, 1'b1);
    for (int i = 1; i <= 8; i++) send_beat(DW'(i), (i == 8));
    wait_done("wr1_done");
    check("wr1_lines", lines_done, 12'd2);
    check("wr1_nwr", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check("wr1_addr0", wr_addr_q[0], 12'h010);
      check("wr1_data0", wr_data_q[0], {32'd4, 32'd3, 32'd2, 32'd1});
      check("wr1_addr1", wr_addr_q[1], 12'h011);
      check("wr1_data1", wr_data_q[1], {32'd8, 32'd7, 32'd6, 32'd5});
    end
    tick();
    check("wr1_idle", busy, 1'b0);
    check("wr1_done_cnt", done_cnt - n, 1);
    $display("txn wr1: writes=%0d lines_done=%0d", wr_addr_q.size(), lines_done);

    // Early tlast leaves the second line partial and ends the job
    clear_logs();
    do_start(1'b0, 12'h020, 12'd3);
    for (int i = 1; i <= 6; i++) send_beat(DW'(i), (i == 6));
    wait_done("wr2_done");
    check("wr2_lines", lines_done, 12'd2);
    check("wr2_nwr", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check("wr2_addr1", wr_addr_q[1], 12'h021);
      check("wr2_data1", wr_data_q[1], {32'd0, 32'd0, 32'd6, 32'd5});
    end
    tick();
    $display("txn wr2: writes=%0d lines_done=%0d", wr_addr_q.size(), lines_done);

    // Read across the address wrap with a toggling m_tready
    clear_logs();
    mem[12'hFFF] = {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001};
    mem[12'h000] = {32'hB000_0004, 32'hB000_0003, 32'hB000_0002, 32'hB000_0001};
    exp_beats = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004,
                  32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004};
    m_tready = 1'b1;
    do_start(1'b1, 12'hFFF, 12'd2);
    stall_prev = 1'b0; prev_data = '0; prev_last = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      if (stall_prev) begin
        check("rd_hold_valid", m_tvalid, 1'b1);
        check("rd_hold_data", m_tdata, prev_data);
        check("rd_hold_last", m_tlast, prev_last);
      end
      m_tready = ~m_tready;
      stall_prev = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
      tick();
      n++;
    end
    check("rd_done", done, 1'b1);
    check("rd_nrd", rd_addr_q.size(), 2);
    if (rd_addr_q.size() == 2) begin
      check("rd_addr0", rd_addr_q[0], 12'hFFF);
      check("rd_addr1", rd_addr_q[1], 12'h000);
    end
    check("rd_nbeats", beat_q.size(), 8);
    if (beat_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("rd_beat%0d", i), beat_q[i], exp_beats[i]);
        check($sformatf("rd_last%0d", i), beat_last_q[i], (i == 7));
      end
    end
    $display("txn rd_wrap: beats=%0d reads=%0d", beat_q.size(), rd_addr_q.size());
    m_tready = 1'b1;
    tick();

    // Read latency and per-line re-request with m_tready held high
    clear_logs();
    mem[12'h100] = {32'h0C00_0004, 32'h0C00_0003, 32'h0C00_0002, 32'h0C00_0001};
    mem[12'h101] = {32'h0D00_0004, 32'h0D00_0003, 32'h0D00_0002, 32'h0D00_0001};
    do_start(1'b1, 12'h100, 12'd2);
    check("lat_req_en", bram_en, 1'b1);
    check("lat_req_we", bram_we, 1'b0);
    check("lat_req_addr", bram_addr, 12'h100);
    cyc = 1;
    while (!m_tvalid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("lat_first_valid", cyc, 4);
    check("lat_first_data", m_tdata, 32'h0C00_0001);
    for (int i = 0; i < 4; i++) tick();
    check("lat_rereq_en", bram_en, 1'b1);
    check("lat_rereq_addr", bram_addr, 12'h101);
    check("lat_rereq_valid", m_tvalid, 1'b0);
    wait_done("lat_done");
    check("lat_lines", lines_done, 12'd2);
    check("lat_nbeats", beat_q.size(), 8);
    $display("txn rd_lat: first_valid_cycle=%0d beats=%0d", cyc, beat_q.size());
    tick();

    // Abort a partial write, then a zero-length job
    clear_logs();
    n = done_cnt;
    do_start(1'b0, 12'h200, 12'd4);
    for (int i = 1; i <= 3; i++) send_beat(DW'(32'h50 + i), 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_sready", s_tready, 1'b0);
    check("abort_lines", lines_done, 12'd0);
    tick();
    check("abort_nwr", wr_addr_q.size(), 0);
    check("abort_no_done", done_cnt - n, 0);
    cyc = en_cnt;
    do_start(1'b0, 12'h300, 12'd0);
    check("zero_done", done, 1'b1);
    check("zero_en", bram_en, 1'b0);
    tick();
    check("zero_idle", busy, 1'b0);
    check("zero_no_access", en_cnt - cyc, 0);
    $display("txn abort+zero: writes=%0d done_pulses=%0d", wr_addr_q.size(), done_cnt - n);

    // Reset in the middle of RD_SEND on the second line
    clear_logs();
    mem[12'h300] = {32'h1111_0004, 32'h1111_0003, 32'h1111_0002, 32'h1111_0001};
    mem[12'h301] = {32'h2222_0004, 32'h2222_0003, 32'h2222_0002, 32'h2222_0001};
    m_tready = 1'b1;
    do_start(1'b1, 12'h300, 12'd2);
    n = 0;
    while (!(m_tvalid && lines_done == 12'd1) && n < 40) begin
      tick();
      n++;
    end
    check("rst_mid_reached", (n < 40), 1'b1);
    m_tready = 1'b0;
    rstn = 1'b0;
    tick();
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_lines", lines_done, '0);
    check("rst_mid_sready", s_tready, 1'b0);
    check("rst_mid_mvalid", m_tvalid, 1'b0);
    check("rst_mid_mlast", m_tlast, 1'b0);
    check("rst_mid_mdata", m_tdata, '0);
    check("rst_mid_en", bram_en, 1'b0);
    check("rst_mid_we", bram_we, 1'b0);
    check("rst_mid_addr", bram_addr, '0);
    check("rst_mid_din", bram_din, '0);
    rstn = 1'b1;
    tick();
    m_tready = 1'b1;
    do_start(1'b1, 12'h300, 12'd1);
    check("post_rst_busy", busy, 1'b1);
    check("post_rst_en", bram_en, 1'b1);
    wait_done("post_rst_done");
    check("post_rst_lines", lines_done, 12'd1);
    $display("txn reset_mid: lines_done=%0d", lines_done);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
